simon_playback_ctrl: RTL and testbench

Sequences playback of the stored Simon pattern onto the four colour LEDs and the tone enable. It sits between the game FSM, the pattern RAM, and a free-running divider tick. On a `start` pulse it walks pattern entries `0..seq_len-1`, lighting each colour for a fixed number of ticks followed by a dark gap, then pulses `done`.

---
 rtl/simon_pkg.sv | 29 ++
 rtl/simon_playback_ctrl.sv | 147 ++++++++++++++
 tb/tb_simon_playback_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared Simon definitions: colour codes, the colour-to-LED mapping and
// elaboration-time helpers used by the game blocks.
package simon_pkg;

   localparam int DEF_MAX_LEN = 32;

   typedef logic [1:0] colour_t;

   localparam colour_t COL_RED    = 2'd0;
   localparam colour_t COL_GREEN  = 2'd1;
   localparam colour_t COL_BLUE   = 2'd2;
   localparam colour_t COL_YELLOW = 2'd3;

   // One-hot LED drive: red on bit 0 through yellow on bit 3.
   function automatic logic [3:0] colour_to_led(input colour_t c);
      return 4'b0001 << c;
   endfunction

   // Ceiling log2 for sizing buses; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/simon_playback_ctrl.sv
// Plays the stored Simon pattern onto the colour LEDs and tone enable,
// one RAM entry at a time, each lit for ON_TICKS then dark for OFF_TICKS.
module simon_playback_ctrl
   import simon_pkg::*;
#(
   parameter  int MAX_LEN   = DEF_MAX_LEN,
   parameter  int ON_TICKS  = 2,
   parameter  int OFF_TICKS = 1,
   localparam int ADDR_W    = clog2(MAX_LEN),
   localparam int LEN_W     = clog2(MAX_LEN + 1)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              start,
   input  logic              abort,
   input  logic [LEN_W-1:0]  seq_len,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [1:0]        rd_data,
   output logic [3:0]        led,
   output logic              tone_en,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = clog2(((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) + 1);
   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_ON, S_OFF, S_DONE
   } state_t;

   state_t             state, state_n;
   logic [LEN_W-1:0]   idx, idx_n;
   logic [LEN_W-1:0]   len, len_n;
   logic [ADDR_W-1:0]  addr_n;
   colour_t            colour, colour_n;
   logic [CNT_W-1:0]   tick_cnt, cnt_n;
   logic [3:0]         led_n;
   logic               tone_en_n, busy_n, done_n;
   logic [LEN_W-1:0]   eff_len;

   assign eff_len = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;

   // NOTE: every variable is given a default before the case so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      len_n    = len;
      addr_n   = rd_addr;
      colour_n = colour;
      cnt_n    = tick_cnt;

      if (abort) begin
         // Cancel wins over everything, including a coincident start in IDLE.
         state_n = S_IDLE;
         cnt_n   = '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  len_n = eff_len;
                  if (eff_len == '0) begin
                     state_n = S_DONE;
                  end else begin
                     idx_n   = '0;
                     addr_n  = '0;
                     state_n = S_FETCH;
                  end
               end
            end
            S_FETCH: state_n = S_LATCH;
            S_LATCH: begin
               colour_n = rd_data;
               cnt_n    = '0;
               state_n  = S_ON;
            end
            S_ON: begin
               if (tick) begin
                  if (tick_cnt == ON_LAST) begin
                     cnt_n   = '0;
                     state_n = S_OFF;
                  end else begin
                     cnt_n = tick_cnt + CNT_W'(1);
                  end
               end
            end
            S_OFF: begin
               if (tick) begin
                  if (tick_cnt == OFF_LAST) begin
                     cnt_n = '0;
                     if (idx == len - LEN_W'(1)) begin
                        state_n = S_DONE;
                     end else begin
                        idx_n   = idx + LEN_W'(1);
                        addr_n  = rd_addr + ADDR_W'(1);
                        state_n = S_FETCH;
                     end
                  end else begin
                     cnt_n = tick_cnt + CNT_W'(1);
                  end
               end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end

      // Outputs are decoded from the next state so they leave the flops aligned with it.
      led_n     = (state_n == S_ON) ? colour_to_led(colour_n) : 4'b0000;
      tone_en_n = (state_n == S_ON);
      busy_n    = (state_n == S_FETCH) || (state_n == S_LATCH) ||
                  (state_n == S_ON)    || (state_n == S_OFF);
      done_n    = (state_n == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         len      <= '0;
         rd_addr  <= '0;
         colour   <= COL_RED;
         tick_cnt <= '0;
         led      <= '0;
         tone_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         len      <= len_n;
         rd_addr  <= addr_n;
         colour   <= colour_n;
         tick_cnt <= cnt_n;
         led      <= led_n;
         tone_en  <= tone_en_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Scoreboard bench for simon_playback_ctrl: stimulus pushes expected LED
// entries and done pulses, a negedge monitor pops and compares them.
module tb_simon_playback_ctrl;

   localparam int MAX_LEN = 4;
   localparam int LEN_W   = 3;
   localparam int ADDR_W  = 2;

   logic              clk, rst_n, tick, start, abort;
   logic [LEN_W-1:0]  seq_len;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_data;
   logic [3:0]        led;
   logic              tone_en, busy, done;

   logic [1:0] mem [MAX_LEN];

   typedef struct {
      logic [3:0] led;
      int         gap;
      int         min_on;
      int         max_on;
   } exp_led_t;

   exp_led_t exp_q[$];
   bit       exp_done_q[$];

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   bit busy_seen = 0;

   simon_playback_ctrl #(
      .MAX_LEN(MAX_LEN), .ON_TICKS(2), .OFF_TICKS(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
      .seq_len(seq_len), .rd_addr(rd_addr), .rd_data(rd_data),
      .led(led), .tone_en(tone_en), .busy(busy), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running divider tick: one pulse every 10 cycles.
   initial begin
      tick = 1'b0;
      forever begin
         repeat (9) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   // Pattern RAM model with one-cycle synchronous read.
   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask

   task automatic push_led(input logic [3:0] l, input int gap, input int mn, input int mx);
      exp_led_t e;
      e.led = l; e.gap = gap; e.min_on = mn; e.max_on = mx;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt > d0) break;
      end
      check("done_seen", done_cnt > d0, 1'b1);
   endtask

   task automatic wait_led(input logic [3:0] v, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (led == v) break;
      end
      check("wait_led", led, v);
   endtask

   task automatic check_drained();
      check("led_queue_empty", exp_q.size(), 0);
      check("done_queue_empty", exp_done_q.size(), 0);
   endtask

   // Monitor: pops an expected entry on every LED rise and every done pulse.
   initial begin
      logic [3:0] prev_led;
      bit         prev_busy, prev_done, eb;
      int         lit, gap;
      exp_led_t   cur;
      prev_led = '0; prev_busy = 0; prev_done = 0; lit = 0; gap = 0;
      cur.led = '0; cur.gap = 0; cur.min_on = 1; cur.max_on = 100000;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_led = '0; prev_busy = 0; prev_done = 0; lit = 0; gap = 0;
         end else begin
            check("tone_tracks_led", tone_en, led != 4'b0000);
            if (led != 0 && prev_led == 0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_led", led, 4'b0000);
                  cur.led = led; cur.gap = 0; cur.min_on = 1; cur.max_on = 100000;
               end else begin
                  cur = exp_q.pop_front();
                  check("led_colour", led, cur.led);
                  check("dark_gap", gap, cur.gap);
               end
               lit = 1;
               gap = 0;
            end else if (led != 0) begin
               lit++;
               if (led != prev_led) check("led_stable", led, prev_led);
            end else begin
               if (prev_led != 0) check_range("on_length", lit, cur.min_on, cur.max_on);
               if (busy) gap++;
               else gap = 0;
            end
            if (done) begin
               done_cnt++;
               if (prev_done) check("done_single_cycle", prev_done, 1'b0);
               if (exp_done_q.size() == 0) begin
                  check("unexpected_done", done, 1'b0);
               end else begin
                  eb = exp_done_q.pop_front();
                  check("busy_low_at_done", busy, 1'b0);
                  check("busy_before_done", prev_busy, eb);
                  check("led_dark_at_done", led, 4'b0000);
               end
            end
            if (busy) busy_seen = 1;
            prev_led  = led;
            prev_busy = busy;
            prev_done = done;
         end
      end
   end

   initial begin
      int d0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; seq_len = '0;
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_led", led, 4'b0000);
      check("rst_tone", tone_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_addr", rd_addr, 2'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic playback {2,0,3} with latency checks
      seq_len = 3'd3;
      push_led(4'b0100, 2, 11, 20);
      push_led(4'b0001, 12, 18, 18);
      push_led(4'b1000, 12, 18, 18);
      exp_done_q.push_back(1'b1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_latency", busy, 1'b1);
      check("led_dark_fetch", led, 4'b0000);
      @(negedge clk);
      check("led_dark_latch", led, 4'b0000);
      @(negedge clk);
      check("led_first_lit", led, 4'b0100);
      wait_done(200);
      repeat (3) @(negedge clk);
      check_drained();

      // Zero length: done next cycle, never busy, never lit
      busy_seen = 0;
      seq_len = 3'd0;
      exp_done_q.push_back(1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("zero_len_done", done, 1'b1);
      repeat (20) @(negedge clk);
      check("zero_len_never_busy", busy_seen, 1'b0);
      check_drained();

      // Clamp: seq_len 7 plays exactly MAX_LEN entries
      mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd0; mem[3] = 2'd2;
      seq_len = 3'd7;
      push_led(4'b0010, 2, 11, 20);
      push_led(4'b1000, 12, 18, 18);
      push_led(4'b0001, 12, 18, 18);
      push_led(4'b0100, 12, 18, 18);
      exp_done_q.push_back(1'b1);
      pulse_start();
      wait_done(300);
      repeat (30) @(negedge clk);
      check_drained();

      // Abort during second ON, then replay from address 0
      seq_len = 3'd3;
      push_led(4'b0010, 2, 11, 20);
      push_led(4'b1000, 12, 1, 18);
      pulse_start();
      wait_led(4'b1000, 100);
      repeat (5) @(negedge clk);
      d0 = done_cnt;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_led", led, 4'b0000);
      check("abort_busy", busy, 1'b0);
      check("abort_tone", tone_en, 1'b0);
      repeat (50) @(negedge clk);
      check("abort_no_done", done_cnt, d0);
      check_drained();
      push_led(4'b0010, 2, 11, 20);
      push_led(4'b1000, 12, 18, 18);
      push_led(4'b0001, 12, 18, 18);
      exp_done_q.push_back(1'b1);
      pulse_start();
      check("replay_addr", rd_addr, 2'd0);
      wait_done(300);
      repeat (3) @(negedge clk);
      check_drained();

      // Start pulses and a seq_len change mid-playback are ignored
      seq_len = 3'd3;
      push_led(4'b0010, 2, 11, 20);
      push_led(4'b1000, 12, 18, 18);
      push_led(4'b0001, 12, 18, 18);
      exp_done_q.push_back(1'b1);
      d0 = done_cnt;
      pulse_start();
      repeat (20) @(negedge clk);
      check("busy_at_extra_start1", busy, 1'b1);
      seq_len = 3'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      check("busy_at_extra_start2", busy, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(300);
      repeat (40) @(negedge clk);
      check("single_done", done_cnt - d0, 1);
      check_drained();

      // Asynchronous reset during OFF of the second entry
      seq_len = 3'd3;
      push_led(4'b0010, 2, 11, 20);
      push_led(4'b1000, 12, 18, 18);
      pulse_start();
      wait_led(4'b1000, 100);
      wait_led(4'b0000, 100);
      repeat (2) @(negedge clk);
      check("addr_before_reset", rd_addr, 2'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_led", led, 4'b0000);
      check("mid_rst_tone", tone_en, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_addr", rd_addr, 2'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_drained();
      seq_len = 3'd1;
      push_led(4'b0010, 2, 11, 20);
      exp_done_q.push_back(1'b1);
      pulse_start();
      check("post_reset_busy", busy, 1'b1);
      wait_done(200);
      repeat (3) @(negedge clk);
      check_drained();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
